// File: rtl/pipeline_trace_buffer_pkg.sv
// Shared FSM state encoding and entry-width helper for the WB-stage trace buffer.
package pipeline_trace_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    // Entry layout, MSB to LSB: {cycle stamp, PC, write-back data}
    function automatic int entry_width(input int cycle_w, input int pc_w, input int data_w);
        return cycle_w + pc_w + data_w;
    endfunction

endpackage

// File: rtl/pipeline_trace_buffer_fifo.sv
// Circular entry store with first-word-fall-through head, flush, and optional overwrite-oldest.
module pipeline_trace_buffer_fifo #(
    parameter int DEPTH     = 16,
    parameter int ENTRY_W   = 80,
    parameter bit WRAP_MODE = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [ENTRY_W-1:0]         entry_i,
    output logic [ENTRY_W-1:0]         entry_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic empty, full, pop_ok, push_full, write_en, head_adv;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign pop_ok    = pop_i && !empty;
    // A pop in the same cycle frees a slot, so only an unpaired push into a full store overflows
    assign push_full = push_i && full && !pop_ok;
    assign write_en  = push_i && (!push_full || WRAP_MODE);
    assign head_adv  = pop_ok || (push_full && WRAP_MODE);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (write_en) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (head_adv) begin
            head_d = head_q + PTR_W'(1);
        end
        if (write_en && !head_adv) begin
            count_d = count_q + CNT_W'(1);
        end else if (head_adv && !write_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (write_en && !rst_i && !flush_i) begin
            mem_q[tail_q] <= entry_i;
        end
    end

    assign valid_o    = !empty;
    assign entry_o    = empty ? '0 : mem_q[head_q];
    assign count_o    = count_q;
    assign overflow_o = push_full;

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Captures (cycle, PC, WB value) tuples from the WB stage after a settle window and drains them FWFT.
module pipeline_trace_buffer
    import pipeline_trace_buffer_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int CYCLE_W     = 16,
    parameter int SKIP_CYCLES = 2,
    parameter bit WRAP_MODE   = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   arm_i,
    input  logic                   stop_pc_en_i,
    input  logic [PC_W-1:0]        stop_pc_i,
    input  logic [CYCLE_W-1:0]     cycle_limit_i,
    input  logic [PC_W-1:0]        pc_i,
    input  logic                   wb_valid_i,
    input  logic [DATA_W-1:0]      wb_data_i,
    input  logic                   rd_ready_i,
    output logic                   rd_valid_o,
    output logic [CYCLE_W-1:0]     rd_cycle_o,
    output logic [PC_W-1:0]        rd_pc_o,
    output logic [DATA_W-1:0]      rd_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic                   capturing_o,
    output logic                   done_o
);

    localparam int ENTRY_W   = entry_width(CYCLE_W, PC_W, DATA_W);
    localparam int SKIP_W    = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;
    localparam int SKIP_LAST = (SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0;

    trace_state_e        state_q, state_d;
    logic [CYCLE_W-1:0]  cycle_q, cycle_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic                overflow_q, overflow_d;

    logic                arm_accept, capturing, stop_hit, push, fifo_ovf;
    logic [ENTRY_W-1:0]  entry_in, entry_out;

    assign capturing  = (state_q == ST_CAPTURE);
    assign arm_accept = arm_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign push       = capturing && wb_valid_i;
    assign stop_hit   = capturing &&
                        (((cycle_limit_i != '0) && (cycle_q == cycle_limit_i - CYCLE_W'(1))) ||
                         (stop_pc_en_i && (pc_i == stop_pc_i)));
    assign entry_in   = {cycle_q, pc_i, wb_data_i};

    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        skip_d     = skip_q;
        overflow_d = overflow_q | fifo_ovf;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_accept) begin
                    state_d    = (SKIP_CYCLES == 0) ? ST_CAPTURE : ST_SKIP;
                    cycle_d    = '0;
                    skip_d     = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_SKIP: begin
                if (skip_q == SKIP_W'(SKIP_LAST)) begin
                    state_d = ST_CAPTURE;
                    skip_d  = '0;
                end else begin
                    skip_d = skip_q + SKIP_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (cycle_q != '1) begin
                    cycle_d = cycle_q + CYCLE_W'(1);
                end
                if (stop_hit) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cycle_q    <= '0;
            skip_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            skip_q     <= skip_d;
            overflow_q <= overflow_d;
        end
    end

    pipeline_trace_buffer_fifo #(
        .DEPTH     (DEPTH),
        .ENTRY_W   (ENTRY_W),
        .WRAP_MODE (WRAP_MODE)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (arm_accept),
        .push_i     (push),
        .pop_i      (rd_ready_i),
        .entry_i    (entry_in),
        .entry_o    (entry_out),
        .valid_o    (rd_valid_o),
        .count_o    (count_o),
        .overflow_o (fifo_ovf)
    );

    assign rd_cycle_o  = entry_out[ENTRY_W-1 -: CYCLE_W];
    assign rd_pc_o     = entry_out[DATA_W +: PC_W];
    assign rd_data_o   = entry_out[DATA_W-1:0];
    assign overflow_o  = overflow_q;
    assign capturing_o = capturing;
    assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench: one 16-deep drop-mode trace buffer plus two 4-deep ones (drop and wrap mode).
module tb_pipeline_trace_buffer;

    localparam logic [31:0] DMASK = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst, arm, stop_pc_en, wb_valid;
    logic [31:0] stop_pc, pc, wb_data;
    logic [15:0] cycle_limit;
    logic        rd_ready, rd_ready_w0, rd_ready_w1;

    logic        rd_valid_m, ovf_m, cap_m, done_m;
    logic [15:0] rd_cycle_m;
    logic [31:0] rd_pc_m, rd_data_m;
    logic [4:0]  count_m;

    logic        rd_valid_w0, ovf_w0, cap_w0, done_w0;
    logic [15:0] rd_cycle_w0;
    logic [31:0] rd_pc_w0, rd_data_w0;
    logic [2:0]  count_w0;

    logic        rd_valid_w1, ovf_w1, cap_w1, done_w1;
    logic [15:0] rd_cycle_w1;
    logic [31:0] rd_pc_w1, rd_data_w1;
    logic [2:0]  count_w1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_trace_buffer #(.DEPTH(16), .SKIP_CYCLES(2), .WRAP_MODE(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .stop_pc_en_i(stop_pc_en), .stop_pc_i(stop_pc),
        .cycle_limit_i(cycle_limit), .pc_i(pc), .wb_valid_i(wb_valid), .wb_data_i(wb_data),
        .rd_ready_i(rd_ready), .rd_valid_o(rd_valid_m), .rd_cycle_o(rd_cycle_m), .rd_pc_o(rd_pc_m),
        .rd_data_o(rd_data_m), .count_o(count_m), .overflow_o(ovf_m), .capturing_o(cap_m),
        .done_o(done_m));

    pipeline_trace_buffer #(.DEPTH(4), .SKIP_CYCLES(2), .WRAP_MODE(1'b0)) dut_w0 (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .stop_pc_en_i(stop_pc_en), .stop_pc_i(stop_pc),
        .cycle_limit_i(cycle_limit), .pc_i(pc), .wb_valid_i(wb_valid), .wb_data_i(wb_data),
        .rd_ready_i(rd_ready_w0), .rd_valid_o(rd_valid_w0), .rd_cycle_o(rd_cycle_w0),
        .rd_pc_o(rd_pc_w0), .rd_data_o(rd_data_w0), .count_o(count_w0), .overflow_o(ovf_w0),
        .capturing_o(cap_w0), .done_o(done_w0));

    pipeline_trace_buffer #(.DEPTH(4), .SKIP_CYCLES(2), .WRAP_MODE(1'b1)) dut_w1 (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .stop_pc_en_i(stop_pc_en), .stop_pc_i(stop_pc),
        .cycle_limit_i(cycle_limit), .pc_i(pc), .wb_valid_i(wb_valid), .wb_data_i(wb_data),
        .rd_ready_i(rd_ready_w1), .rd_valid_o(rd_valid_w1), .rd_cycle_o(rd_cycle_w1),
        .rd_pc_o(rd_pc_w1), .rd_data_o(rd_data_w1), .count_o(count_w1), .overflow_o(ovf_w1),
        .capturing_o(cap_w1), .done_o(done_w1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] v);
        pc      = v;
        wb_data = v ^ DMASK;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wb_valid = k[0];
            step();
        end
        rst = 1'b0;
        wb_valid = 1'b1;
        step();
        n_checks++;
        if ({count_m, rd_valid_m, done_m, ovf_m, cap_m} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_state got count=%0d valid=%0b done=%0b ovf=%0b cap=%0b exp all 0",
                     count_m, rd_valid_m, done_m, ovf_m, cap_m);
        end
        n_checks++;
        if ({rd_cycle_m, rd_pc_m, rd_data_m} !== 80'b0) begin
            n_fail++;
            $display("FAIL reset_rd_fields got cycle=%0h pc=%0h data=%0h exp 0",
                     rd_cycle_m, rd_pc_m, rd_data_m);
        end
    endtask

    task automatic test_skip_window();
        int exp_cnt;
        cycle_limit = 16'd3;
        stop_pc_en  = 1'b0;
        wb_valid    = 1'b1;
        arm         = 1'b1;
        set_pc(32'hFC);
        step();
        arm = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_pc(32'(4 * k));
            step();
            exp_cnt = (k < 2) ? 0 : ((k > 4) ? 3 : k - 1);
            n_checks++;
            if (count_m !== 5'(exp_cnt)) begin
                n_fail++;
                $display("FAIL skip_count k=%0d got=%0d exp=%0d", k, count_m, exp_cnt);
            end
        end
        n_checks++;
        if (done_m !== 1'b1) begin
            n_fail++;
            $display("FAIL skip_done got=%0b exp=1", done_m);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd_valid_m !== 1'b1 || rd_cycle_m !== 16'(i) || rd_pc_m !== 32'(8 + 4 * i) ||
                rd_data_m !== (32'(8 + 4 * i) ^ DMASK)) begin
                n_fail++;
                $display("FAIL skip_entry%0d got v=%0b cyc=%0d pc=%0h data=%0h exp v=1 cyc=%0d pc=%0h",
                         i, rd_valid_m, rd_cycle_m, rd_pc_m, rd_data_m, i, 8 + 4 * i);
            end
            rd_ready = 1'b1;
            step();
        end
        rd_ready = 1'b0;
        n_checks++;
        if (rd_valid_m !== 1'b0 || count_m !== 5'd0) begin
            n_fail++;
            $display("FAIL skip_drained got v=%0b count=%0d exp v=0 count=0", rd_valid_m, count_m);
        end
    endtask

    task automatic test_cycle_limit();
        cycle_limit = 16'd5;
        arm = 1'b1;
        set_pc(32'h100);
        step();
        arm = 1'b0;
        for (int k = 0; k < 9; k++) begin
            set_pc(32'h100 + 32'(4 * k));
            step();
            if (k == 1) begin
                n_checks++;
                if (cap_m !== 1'b1) begin
                    n_fail++;
                    $display("FAIL limit_capturing got=%0b exp=1", cap_m);
                end
            end
            if (k == 5 || k == 6) begin
                n_checks++;
                if (done_m !== (k == 6) || cap_m !== (k == 5)) begin
                    n_fail++;
                    $display("FAIL limit_stop k=%0d got done=%0b cap=%0b exp done=%0b cap=%0b",
                             k, done_m, cap_m, k == 6, k == 5);
                end
            end
        end
        n_checks++;
        if (count_m !== 5'd5) begin
            n_fail++;
            $display("FAIL limit_count got=%0d exp=5", count_m);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rd_cycle_m !== 16'(i) || rd_pc_m !== 32'h100 + 32'(4 * (i + 2))) begin
                n_fail++;
                $display("FAIL limit_entry%0d got cyc=%0d pc=%0h exp cyc=%0d pc=%0h",
                         i, rd_cycle_m, rd_pc_m, i, 32'h100 + 4 * (i + 2));
            end
            rd_ready = 1'b1;
            step();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_pc_stop();
        int exp_st [6] = '{0, 1, 3, 4, 5, 6};
        cycle_limit = 16'd0;
        stop_pc_en  = 1'b1;
        stop_pc     = 32'h20;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int k = 0; k < 11; k++) begin
            set_pc(32'(4 * k));
            wb_valid = (k != 4);
            arm      = (k == 5);
            step();
            if (k == 7 || k == 8) begin
                n_checks++;
                if (done_m !== (k == 8)) begin
                    n_fail++;
                    $display("FAIL pcstop_done k=%0d got=%0b exp=%0b", k, done_m, k == 8);
                end
            end
        end
        arm = 1'b0;
        wb_valid = 1'b1;
        stop_pc_en = 1'b0;
        n_checks++;
        if (count_m !== 5'd6) begin
            n_fail++;
            $display("FAIL pcstop_count got=%0d exp=6", count_m);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (rd_cycle_m !== 16'(exp_st[i]) || rd_pc_m !== 32'(8 + 4 * exp_st[i])) begin
                n_fail++;
                $display("FAIL pcstop_entry%0d got cyc=%0d pc=%0h exp cyc=%0d pc=%0h",
                         i, rd_cycle_m, rd_pc_m, exp_st[i], 8 + 4 * exp_st[i]);
            end
            rd_ready = 1'b1;
            step();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_full_modes();
        cycle_limit = 16'd6;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int k = 0; k < 10; k++) begin
            set_pc(32'h40 + 32'(4 * k));
            step();
            if (k == 5 || k == 6) begin
                n_checks++;
                if (count_w0 !== 3'd4 || ovf_w0 !== (k == 6) || ovf_w1 !== (k == 6)) begin
                    n_fail++;
                    $display("FAIL full_ovf k=%0d got cnt=%0d ovf0=%0b ovf1=%0b exp cnt=4 ovf=%0b",
                             k, count_w0, ovf_w0, ovf_w1, k == 6);
                end
            end
        end
        n_checks++;
        if (count_w1 !== 3'd4 || ovf_w1 !== 1'b1 || done_w0 !== 1'b1) begin
            n_fail++;
            $display("FAIL full_end got cnt1=%0d ovf1=%0b done0=%0b exp 4 1 1",
                     count_w1, ovf_w1, done_w0);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_cycle_w0 !== 16'(i) || rd_pc_w0 !== 32'h40 + 32'(4 * (i + 2)) ||
                rd_cycle_w1 !== 16'(i + 2) || rd_pc_w1 !== 32'h40 + 32'(4 * (i + 4)) ||
                rd_data_w1 !== ((32'h40 + 32'(4 * (i + 4))) ^ DMASK)) begin
                n_fail++;
                $display("FAIL full_entry%0d got cyc0=%0d pc0=%0h cyc1=%0d pc1=%0h exp %0d %0h %0d %0h",
                         i, rd_cycle_w0, rd_pc_w0, rd_cycle_w1, rd_pc_w1,
                         i, 32'h40 + 4 * (i + 2), i + 2, 32'h40 + 4 * (i + 4));
            end
            rd_ready_w0 = 1'b1;
            rd_ready_w1 = 1'b1;
            step();
        end
        rd_ready_w0 = 1'b0;
        rd_ready_w1 = 1'b0;
    endtask

    task automatic test_back_to_back_and_reset();
        cycle_limit = 16'd0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_pc(32'h200 + 32'(4 * k));
            step();
        end
        n_checks++;
        if (count_w0 !== 3'd4 || count_w1 !== 3'd4 || ovf_w0 !== 1'b0 || ovf_w1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_fill got cnt0=%0d cnt1=%0d ovf0=%0b ovf1=%0b exp 4 4 0 0",
                     count_w0, count_w1, ovf_w0, ovf_w1);
        end
        rd_ready_w0 = 1'b1;
        rd_ready_w1 = 1'b1;
        set_pc(32'h218);
        step();
        rd_ready_w0 = 1'b0;
        rd_ready_w1 = 1'b0;
        n_checks++;
        if (count_w0 !== 3'd4 || count_w1 !== 3'd4 || ovf_w0 !== 1'b0 || ovf_w1 !== 1'b0 ||
            rd_cycle_w0 !== 16'd1 || rd_cycle_w1 !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_pushpop got cnt0=%0d cnt1=%0d ovf0=%0b ovf1=%0b cyc0=%0d cyc1=%0d exp 4 4 0 0 1 1",
                     count_w0, count_w1, ovf_w0, ovf_w1, rd_cycle_w0, rd_cycle_w1);
        end
        set_pc(32'h21C);
        step();
        n_checks++;
        if (count_w0 !== 3'd4 || ovf_w0 !== 1'b1 || ovf_w1 !== 1'b1 ||
            rd_cycle_w0 !== 16'd1 || rd_cycle_w1 !== 16'd2 || cap_w0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_overrun got cnt0=%0d ovf0=%0b ovf1=%0b cyc0=%0d cyc1=%0d cap=%0b exp 4 1 1 1 2 1",
                     count_w0, ovf_w0, ovf_w1, rd_cycle_w0, rd_cycle_w1, cap_w0);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({count_w0, count_w1, count_m} !== 11'b0 ||
            {rd_valid_w0, rd_valid_w1, rd_valid_m, ovf_w0, ovf_w1, cap_w0, cap_w1, cap_m} !== 8'b0 ||
            rd_data_w1 !== 32'b0) begin
            n_fail++;
            $display("FAIL midrst got cnt0=%0d cnt1=%0d cntm=%0d v1=%0b ovf0=%0b ovf1=%0b cap0=%0b data1=%0h exp all 0",
                     count_w0, count_w1, count_m, rd_valid_w1, ovf_w0, ovf_w1, cap_w0, rd_data_w1);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (cap_w1 !== 1'b0 || done_w1 !== 1'b0 || count_w1 !== 3'd0) begin
            n_fail++;
            $display("FAIL post_rst_idle got cap=%0b done=%0b cnt=%0d exp 0 0 0",
                     cap_w1, done_w1, count_w1);
        end
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; stop_pc_en = 1'b0; stop_pc = 32'h0; cycle_limit = 16'd0;
        wb_valid = 1'b0; rd_ready = 1'b0; rd_ready_w0 = 1'b0; rd_ready_w1 = 1'b0;
        set_pc(32'h0);
        test_reset();
        test_skip_window();
        test_cycle_limit();
        test_pc_stop();
        test_full_modes();
        test_back_to_back_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
